// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scanner for a NUM_DIGITS-digit seven-segment display.
//   It latches a NUM_DIGITS x 4-bit value and walks through its nibbles,
//   one digit per refresh slot of REFRESH_DIV cycles. The first DEAD_CYCLES
//   cycles of each slot keep every digit off, which suppresses ghosting.
//   During that time the next digit's nibble is already on the decoder.
//
// Optional feature:
//   `define SEVEN_SEG_SCAN_BLANK_EN  -> leading-zero blanking. blank is
//   raised while digit k>0 is lit and nibbles k..NUM_DIGITS-1 are all zero.
//   When the macro is undefined, blank is tied to 0.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_val    in   value to display; nibble k drives digit k
//   in_en     in   capture in_val into the display register at this edge
//   nibble    out  nibble of the currently scanned digit (decoder input)
//   digit_en  out  one-hot active-high digit enable; zero during dead time
//   blank     out  force all segments off (leading-zero blanking)
//
// All outputs are decoded from registers only. No input reaches an output
// combinationally.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] in_val,
  input  logic                    in_en,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [CW-1:0]           cnt_reg;
  logic [CW-1:0]           cnt_next;
  logic [IW-1:0]           idx_reg;
  logic [IW-1:0]           idx_next;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic                    slot_end;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DEAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DEAD: if (cnt_reg == CNT_DEAD_LAST) state_next = ON;
      ON:   if (cnt_reg == CNT_LAST)      state_next = DEAD;
      default: state_next = DEAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------
  assign slot_end = (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    idx_next = idx_reg;
    if (slot_end) begin
      cnt_next = '0;
      // Explicit wrap, because NUM_DIGITS need not be a power of two.
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      idx_reg  <= '0;
      disp_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      // A load never disturbs the scan position. On a slot wrap, the new
      // idx reads the newly loaded value on the following cycle.
      if (in_en) begin
        disp_reg <= in_val;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero detection (optional)
  // ---------------------------------------------------------------------
`ifdef SEVEN_SEG_SCAN_BLANK_EN
  // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the display value are all zero.
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  blank_cond;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (disp_reg[4*NUM_DIGITS-1 : 4*gi] == '0);
    end
  endgenerate

  // Digit 0 is never blanked, so a value of zero still shows "0".
  assign blank_cond = (idx_reg != '0) && upper_zero[idx_reg];
`endif

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    digit_en = '0;
    blank    = 1'b0;
    if (state_reg == ON) begin
      digit_en = NUM_DIGITS'(1) << idx_reg;
`ifdef SEVEN_SEG_SCAN_BLANK_EN
      blank = blank_cond;
`endif
    end
  end

  // The nibble is presented in both states. The decoder therefore settles
  // while the digit is still dark.
  assign nibble = disp_reg[{idx_reg, 2'b00} +: 4];

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_val;
  logic        in_en;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic        blank;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_en   (in_en),
    .nibble  (nibble),
    .digit_en(digit_en),
    .blank   (blank)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nib;
    logic       blk;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // Reference model: elapsed cycles since reset, plus the loaded value.
  int          t_model;
  logic [15:0] d_model;

  // Expected outputs after t edges since reset, derived arithmetically.
  function automatic exp_t model_out(input int t, input logic [15:0] d);
    exp_t        e;
    int          pos;
    int          k;
    bit          on;
    logic [15:0] upper;
    pos   = t % RD;
    k     = (t / RD) % ND;
    on    = (pos >= DC);
    e.en  = on ? 4'(1 << k) : 4'b0000;
    e.nib = 4'((d >> (4 * k)) & 16'h000F);
    upper = d >> (4 * k);
`ifdef SEVEN_SEG_SCAN_BLANK_EN
    e.blk = on && (k > 0) && (upper == 16'h0000);
`else
    e.blk = 1'b0;
    if (upper == 16'hFFFF) e.blk = 1'b0;
`endif
    return e;
  endfunction

  // Drive inputs for one edge, then advance the model and queue the expectation.
  task automatic step(input logic r, input logic en, input logic [15:0] v);
    rst    = r;
    in_en  = en;
    in_val = v;
    @(posedge clk);
    #1;
    if (r) begin
      t_model = 0;
      d_model = 16'h0000;
    end else begin
      t_model = t_model + 1;
      if (en) d_model = v;
    end
    exp_q.push_back(model_out(t_model, d_model));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
  endtask

  // Advance until the model state after the last edge satisfies k/pos.
  task automatic run_to(input int k, input int pos);
    for (int i = 0; i < 64; i++) begin
      if (((t_model / RD) % ND) == k && (t_model % RD) == pos) return;
      step(1'b0, 1'b0, 16'h0000);
    end
  endtask

  // Monitor: outputs are valid every cycle, so sample each negedge.
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (digit_en !== e.en || nibble !== e.nib || blank !== e.blk) begin
          failures++;
          $display("FAIL outputs t=%0d: got digit_en=%b nibble=%h blank=%b, expected digit_en=%b nibble=%h blank=%b",
                   $time, digit_en, nibble, blank, e.en, e.nib, e.blk);
        end else begin
          $display("ok t=%0d digit_en=%b nibble=%h blank=%b", $time, digit_en, nibble, blank);
        end
      end
    end
  end

  initial begin : driver
    rst     = 1'b1;
    in_en   = 1'b0;
    in_val  = 16'h0000;
    t_model = 0;
    d_model = 16'h0000;

    // Reset state, then one full idle scan period and a partial repeat.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF);
    idle(20);

    // Load A5C3 and watch a full scan.
    run_to(0, 0);
    step(1'b0, 1'b1, 16'hA5C3);
    idle(16);

    // Mid-slot update during digit 1 ON.
    run_to(1, 1);
    step(1'b0, 1'b1, 16'h00F0);
    idle(6);

    // Load on the same edge as the idx 3 -> 0 wrap.
    run_to(3, RD - 1);
    step(1'b0, 1'b1, 16'h1234);
    idle(4);

    // Reset during digit 2 ON.
    run_to(2, 2);
    step(1'b1, 1'b0, 16'h0000);
    idle(8);

    // Leading-zero patterns.
    run_to(0, 0);
    step(1'b0, 1'b1, 16'h0070);
    idle(16);
    step(1'b0, 1'b1, 16'h0000);
    idle(16);

    // Randomized traffic: occasional loads, sustained loads and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      int          r;
      r = $urandom_range(0, 99);
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      if ($urandom_range(0, 7) == 0) v = v & 16'h000F;
      if (r == 0)      step(1'b1, 1'($urandom_range(0, 1)), v);
      else if (r < 15) step(1'b0, 1'b1, v);
      else             step(1'b0, 1'b0, v);
    end

    // Let the monitor drain; a leftover entry means it stalled.
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed display scanner that sits directly upstream of the binary-to-seven-segment decoder. It latches a NUM_DIGITS×4-bit value and cycles through its nibbles, one digit per refresh slot. Each slot presents that digit's nibble to the decoder and drives a one-hot digit-enable bus to the display's common pins. A dead-time phase at the start of each slot suppresses ghosting between adjacent digits.

## Interface
- NUM_DIGITS, 4: digits scanned; 2..8.
- REFRESH_DIV, 1000: clock cycles per digit slot; ≥ 2.
- DEAD_CYCLES, 2: leading cycles of each slot with all digits off; 1 ≤ DEAD_CYCLES < REFRESH_DIV.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_val  input  4·NUM_DIGITS  value to display; nibble k drives digit k (digit 0 = least significant).
- in_en  input  1  when 1, in_val is captured into the display register at this edge.
- nibble  output  4  current digit's nibble; connects to the decoder input.
- digit_en  output  NUM_DIGITS  one-hot active-high digit enable; all-zero during dead time.
- blank  output  1  when 1, downstream forces all segments off (seg = 7'h7F).

## Operation
- Registers:
  - disp_reg: 4·NUM_DIGITS bits.
  - cnt: $clog2(REFRESH_DIV) bits; counts 0..REFRESH_DIV-1.
  - idx: $clog2(NUM_DIGITS) bits.
  - state: DEAD or ON.
- All outputs are functions of registers only. There is no combinational path from in_val or in_en to any output.
- cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0.
- State transitions:
  - DEAD → ON when cnt == DEAD_CYCLES-1.
  - ON → DEAD when cnt == REFRESH_DIV-1. idx advances on the same edge, wrapping NUM_DIGITS-1 → 0.
- Outputs by state:
  - DEAD: digit_en = 0.
  - ON: digit_en = 1 << idx.
- nibble = disp_reg[4·idx +: 4] in both states. The decoder therefore settles during dead time.
- in_en: disp_reg ← in_val at the edge. The new value is visible on nibble the next cycle, including mid-slot. The scan position is not disturbed.
- Simultaneous in_en and slot wrap: both take effect on the same edge. The new idx reads the new disp_reg.
- in_en held high: disp_reg tracks in_val every cycle.

## Timing
- Reset values:
  - disp_reg=0, cnt=0, idx=0, state=DEAD.
  - digit_en=0, nibble=4'h0, blank=0.
- Cycle 0 is the first edge after rst deasserts.
  - digit_en = 0 for cycles 0..DEAD_CYCLES-1.
  - digit_en = 1 for cycles DEAD_CYCLES..REFRESH_DIV-1.
  - Digit 1's DEAD phase starts at cycle REFRESH_DIV.
- Full scan period: NUM_DIGITS·REFRESH_DIV cycles. Each digit is on for REFRESH_DIV-DEAD_CYCLES cycles per period.
- in_en → nibble latency: 1 cycle.
- rst asserted mid-slot: at the next edge all registers return to reset values. digit_en is 0 on the following cycle. disp_reg is cleared; the displayed value is lost.
- digit_en is never multi-hot. digit_en is never nonzero in DEAD.

## Configuration
- SEVEN_SEG_SCAN_BLANK_EN (leading-zero blanking).
- Defined:
  - blank=1 during the ON phase of digit k when k > 0 and nibbles k..NUM_DIGITS-1 of disp_reg are all zero.
  - Digit 0 is never blanked; a value of 0 displays "0".
  - blank=0 in DEAD.
  - blank is registered alongside digit_en.
- Undefined: blank is constant 0 and no blanking logic is synthesized.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.

- Reset then idle, in_val never loaded:
  - digit_en sequence 0000, 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, then repeats.
  - nibble = 0 throughout.
- in_en with in_val=16'hA5C3:
  - nibble shows 3, C, 5, A in digits 0..3 on the next scan.
  - On digit 2's ON cycles, digit_en=0100 and nibble=4'h5.
- Mid-slot update: during digit 1 ON, load 16'h00F0 → nibble becomes 4'hF on the next cycle with no idx change.
- Simultaneous wrap and load: in_en=1 with 16'h1234 on the edge where idx goes 3→0 → the first cycle after that edge shows idx=0, digit_en=0000 (DEAD), nibble=4'h4.
- Reset mid-operation: assert rst for 1 cycle during digit 2 ON → next cycle digit_en=0000, nibble=0, and the scan restarts from digit 0.
- With SEVEN_SEG_SCAN_BLANK_EN:
  - Load 16'h0070 → blank=1 on digit 3 and digit 2 ON cycles; blank=0 on digits 0 and 1.
  - Load 16'h0000 → only digits 1..3 blanked.
  - Without the macro, blank stays 0 for both values.
